pi_steer: RTL and testbench

PI_STEER -- requirements
Module: pi_steer

---
 rtl/pi_steer_pkg.sv | 33 +++
 rtl/pi_steer_sat.sv | 25 ++
 rtl/pi_steer.sv | 144 ++++++++++++++
 tb/tb_pi_steer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_steer_pkg.sv
// Shared types and widths for the pi_steer line-following steering controller.
package pi_steer_pkg;

    localparam int ERR_W   = 12;
    localparam int ESAT_W  = 10;
    localparam int SPD_W   = 10;
    localparam int DRV_W   = 11;
    localparam int INTEG_W = 16;
    localparam int PTERM_W = 13;

    localparam logic signed [INTEG_W-1:0] INTEG_LIM     = 16'sd16383;
    localparam logic signed [INTEG_W:0]   INTEG_LIM_EXT = 17'sd16383;

    typedef enum logic [2:0] {
        IDLE,
        CALC_P,
        CALC_I,
        SUM,
        DRIVE
    } state_t;

    // Symmetric clamp; the limit is not a power of two so a plain saturator does not fit.
    function automatic logic signed [INTEG_W-1:0] clamp_integ(input logic signed [INTEG_W:0] v);
        if (v > INTEG_LIM_EXT) begin
            return INTEG_LIM;
        end else if (v < -INTEG_LIM_EXT) begin
            return -INTEG_LIM;
        end else begin
            return v[INTEG_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pi_steer_sat.sv
// Signed saturator: clamps a two's-complement value into a narrower signed range.
module sat_signed #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  value,
    output logic signed [OUT_W-1:0] result
);

    localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    logic [IN_W-OUT_W:0] top_bits;

    // Value fits when every bit above the output MSB repeats the sign.
    assign top_bits = value[IN_W-1:OUT_W-1];

    always_comb begin
        result = value[OUT_W-1:0];
        if (!((&top_bits) || !(|top_bits))) begin
            result = value[IN_W-1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/pi_steer.sv
// PI steering controller: one error sample in, left/right drive commands out four edges later.
module pi_steer
    import pi_steer_pkg::*;
#(
    parameter int KP       = 3,
    parameter int KI_SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        err_vld,
    input  logic [11:0] error,
    input  logic [9:0]  fwd_spd,
    output logic [10:0] lft,
    output logic [10:0] rht,
    output logic        upd_done,
    output logic        busy
);

    localparam int CSUM_W = INTEG_W + 1;
    localparam int DSUM_W = DRV_W + 1;
    localparam logic signed [PTERM_W-1:0] KP_S = PTERM_W'(KP);

    state_t state_reg, state_next;

    logic signed [ERR_W-1:0]   error_reg;
    logic signed [ESAT_W-1:0]  err_sat, err_sat_reg;
    logic signed [PTERM_W-1:0] p_next, p_term_reg;
    logic signed [CSUM_W-1:0]  integ_sum;
    logic signed [INTEG_W-1:0] integ_reg;
    logic signed [CSUM_W-1:0]  corr_sum;
    logic signed [DRV_W-1:0]   corr_sat, corr_reg;
    logic signed [DRV_W-1:0]   lft_reg, rht_reg;
    logic signed [DSUM_W-1:0]  fwd_ext;
    logic signed [DSUM_W-1:0]  drive_sum [2];
    logic signed [DRV_W-1:0]   drive_sat [2];
    logic                      upd_reg;

    sat_signed #(.IN_W(ERR_W), .OUT_W(ESAT_W)) u_err_sat (
        .value  (error_reg),
        .result (err_sat)
    );

    assign p_next    = PTERM_W'(err_sat) * KP_S;
    assign integ_sum = CSUM_W'(integ_reg) + CSUM_W'(err_sat_reg);
    // Sum carried wide enough that no KI_SHIFT setting can wrap before saturation.
    assign corr_sum  = CSUM_W'(p_term_reg) + CSUM_W'(integ_reg >>> KI_SHIFT);

    sat_signed #(.IN_W(CSUM_W), .OUT_W(DRV_W)) u_corr_sat (
        .value  (corr_sum),
        .result (corr_sat)
    );

    assign fwd_ext = DSUM_W'({1'b0, fwd_spd});

    // Index 0 is the left wheel (speed + correction), index 1 the right wheel.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_side
            if (gi == 0) begin : g_add
                assign drive_sum[gi] = fwd_ext + DSUM_W'(corr_reg);
            end else begin : g_sub
                assign drive_sum[gi] = fwd_ext - DSUM_W'(corr_reg);
            end
            sat_signed #(.IN_W(DSUM_W), .OUT_W(DRV_W)) u_drive_sat (
                .value  (drive_sum[gi]),
                .result (drive_sat[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (err_vld) state_next = CALC_P;
            CALC_P:  state_next = CALC_I;
            CALC_I:  state_next = SUM;
            SUM:     state_next = DRIVE;
            DRIVE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (!go) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        busy = 1'b0;
        if (state_reg != IDLE) begin
            busy = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            error_reg   <= '0;
            err_sat_reg <= '0;
            p_term_reg  <= '0;
            integ_reg   <= '0;
            corr_reg    <= '0;
            lft_reg     <= '0;
            rht_reg     <= '0;
            upd_reg     <= 1'b0;
        end else if (!go) begin
            integ_reg <= '0;
            lft_reg   <= '0;
            rht_reg   <= '0;
            upd_reg   <= 1'b0;
        end else begin
            upd_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (err_vld) begin
                        error_reg <= error;
                    end
                end
                CALC_P: begin
                    err_sat_reg <= err_sat;
                    p_term_reg  <= p_next;
                end
                CALC_I: integ_reg <= clamp_integ(integ_sum);
                SUM:    corr_reg  <= corr_sat;
                DRIVE: begin
                    lft_reg <= drive_sat[0];
                    rht_reg <= drive_sat[1];
                    upd_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign lft      = lft_reg;
    assign rht      = rht_reg;
    assign upd_done = upd_reg;

endmodule

// File: tb/tb_pi_steer.sv
// Self-checking bench for pi_steer: directed scenarios plus randomized updates against an integer model.
module tb_pi_steer;

    localparam int KP       = 3;
    localparam int KI_SHIFT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        err_vld = 1'b0;
    logic [11:0] error = '0;
    logic [9:0]  fwd_spd = '0;
    logic [10:0] lft, rht;
    logic        upd_done, busy;

    int vectors = 0;
    int miscompares = 0;

    int m_integ, m_lft, m_rht;

    pi_steer #(.KP(KP), .KI_SHIFT(KI_SHIFT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (go),
        .err_vld  (err_vld),
        .error    (error),
        .fwd_spd  (fwd_spd),
        .lft      (lft),
        .rht      (rht),
        .upd_done (upd_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_clear();
        m_integ = 0;
        m_lft   = 0;
        m_rht   = 0;
    endtask

    task automatic model_update(input logic [11:0] e, input logic [9:0] f);
        int es, p, corr, fi;
        es      = clampi(int'($signed(e)), -512, 511);
        p       = KP * es;
        m_integ = clampi(m_integ + es, -16383, 16383);
        corr    = clampi(p + (m_integ >>> KI_SHIFT), -1024, 1023);
        fi      = int'(f);
        m_lft   = clampi(fi + corr, -1024, 1023);
        m_rht   = clampi(fi - corr, -1024, 1023);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        go      = 1'b1;
        err_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    // Strobe one error sample and observe the following ten cycles.
    task automatic run_update(input logic [11:0] e, input logic [9:0] f,
                              output int lat, output int bcnt, output int ucnt);
        @(posedge clk);
        #1;
        error   = e;
        fwd_spd = f;
        err_vld = 1'b1;
        @(posedge clk);
        #1 err_vld = 1'b0;
        lat  = -1;
        bcnt = 0;
        ucnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (busy) bcnt++;
            if (upd_done) begin
                ucnt++;
                if (lat < 0) lat = k;
            end
            @(posedge clk);
            #1;
        end
        $display("update error=%0d fwd=%0d -> lft=%0d rht=%0d lat=%0d busy=%0d pulses=%0d",
                 $signed(e), f, $signed(lft), $signed(rht), lat, bcnt, ucnt);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        go      = 1'b1;
        err_vld = 1'b1;
        error   = 12'd100;
        fwd_spd = 10'd200;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (lft !== 11'd0) begin miscompares++; $display("FAIL reset_lft got %h want 000", lft); end
        vectors++;
        if (rht !== 11'd0) begin miscompares++; $display("FAIL reset_rht got %h want 000", rht); end
        vectors++;
        if (upd_done !== 1'b0) begin miscompares++; $display("FAIL reset_upd got %b want 0", upd_done); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        err_vld = 1'b0;
        rst_n   = 1'b1;
        model_clear();
        $display("reset checked");
    endtask

    task automatic test_basic();
        int lat, bcnt, ucnt;
        do_reset();
        run_update(12'd100, 10'd200, lat, bcnt, ucnt);
        vectors++;
        if (lft !== 11'h1FA) begin miscompares++; $display("FAIL basic_lft got %h want 1fa", lft); end
        vectors++;
        if (rht !== 11'h796) begin miscompares++; $display("FAIL basic_rht got %h want 796", rht); end
        vectors++;
        if (lat !== 4) begin miscompares++; $display("FAIL basic_latency got %0d want 4", lat); end
        vectors++;
        if (bcnt !== 4) begin miscompares++; $display("FAIL basic_busy_cycles got %0d want 4", bcnt); end
        vectors++;
        if (ucnt !== 1) begin miscompares++; $display("FAIL basic_pulses got %0d want 1", ucnt); end
    endtask

    task automatic test_sat_hi();
        int lat, bcnt, ucnt;
        do_reset();
        run_update(12'h7FF, 10'd500, lat, bcnt, ucnt);
        vectors++;
        if (lft !== 11'h3FF) begin miscompares++; $display("FAIL sat_hi_lft got %h want 3ff", lft); end
        vectors++;
        if (rht !== 11'h5F5) begin miscompares++; $display("FAIL sat_hi_rht got %h want 5f5", rht); end
    endtask

    task automatic test_integ_clamp();
        int lat, bcnt, ucnt;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            run_update(12'hDA8, 10'd0, lat, bcnt, ucnt);
            model_update(12'hDA8, 10'd0);
            vectors++;
            if (lft !== 11'(m_lft) || rht !== 11'(m_rht)) begin
                miscompares++;
                $display("FAIL integ_step%0d got %h/%h want %h/%h", i, lft, rht, 11'(m_lft), 11'(m_rht));
            end
        end
        vectors++;
        if (lft !== 11'h400) begin miscompares++; $display("FAIL integ_clamp_lft got %h want 400", lft); end
        vectors++;
        if (rht !== 11'h3FF) begin miscompares++; $display("FAIL integ_clamp_rht got %h want 3ff", rht); end
    endtask

    task automatic test_back_to_back();
        int ucnt;
        do_reset();
        @(posedge clk);
        #1;
        error = 12'd100; fwd_spd = 10'd200; err_vld = 1'b1;
        @(posedge clk);
        #1 error = 12'd300;
        @(posedge clk);
        #1 error = 12'd50;
        @(posedge clk);
        #1 err_vld = 1'b0;
        ucnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (upd_done) ucnt++;
            @(posedge clk);
            #1;
        end
        $display("back_to_back -> lft=%0d rht=%0d pulses=%0d", $signed(lft), $signed(rht), ucnt);
        vectors++;
        if (ucnt !== 1) begin miscompares++; $display("FAIL b2b_pulses got %0d want 1", ucnt); end
        vectors++;
        if (lft !== 11'h1FA || rht !== 11'h796) begin
            miscompares++;
            $display("FAIL b2b_result got %h/%h want 1fa/796", lft, rht);
        end
    endtask

    task automatic test_go_drop();
        int lat, bcnt, ucnt;
        do_reset();
        run_update(12'd100, 10'd200, lat, bcnt, ucnt);
        @(posedge clk);
        #1;
        error = 12'd100; err_vld = 1'b1;
        @(posedge clk);
        #1 err_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1 go = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (lft !== 11'd0 || rht !== 11'd0) begin
            miscompares++;
            $display("FAIL go_drop_outputs got %h/%h want 000/000", lft, rht);
        end
        vectors++;
        if (busy !== 1'b0 || upd_done !== 1'b0) begin
            miscompares++;
            $display("FAIL go_drop_flags got busy=%b upd=%b want 0/0", busy, upd_done);
        end
        go = 1'b1;
        ucnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (upd_done) ucnt++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (ucnt !== 0) begin miscompares++; $display("FAIL go_drop_no_pulse got %0d want 0", ucnt); end
        run_update(12'd100, 10'd200, lat, bcnt, ucnt);
        vectors++;
        if (lft !== 11'h1FA || rht !== 11'h796) begin
            miscompares++;
            $display("FAIL go_drop_rerun got %h/%h want 1fa/796", lft, rht);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, ucnt;
        do_reset();
        run_update(12'd300, 10'd100, lat, bcnt, ucnt);
        @(posedge clk);
        #1;
        error = 12'd200; err_vld = 1'b1;
        @(posedge clk);
        #1 err_vld = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (lft !== 11'd0 || rht !== 11'd0 || busy !== 1'b0 || upd_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid got lft=%h rht=%h busy=%b upd=%b want 000/000/0/0",
                     lft, rht, busy, upd_done);
        end
        rst_n = 1'b1;
        ucnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (upd_done || busy) ucnt++;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (ucnt !== 0 || lft !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet got activity=%0d lft=%h want 0/000", ucnt, lft);
        end
        model_clear();
    endtask

    task automatic test_random();
        int lat, bcnt, ucnt;
        logic [11:0] e;
        logic [9:0]  f;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1 go = 1'b0;
                @(posedge clk);
                #1 go = 1'b1;
                model_clear();
                vectors++;
                if (lft !== 11'd0 || rht !== 11'd0) begin
                    miscompares++;
                    $display("FAIL rand_go_low%0d got %h/%h want 000/000", i, lft, rht);
                end
            end
            if ($urandom_range(0, 1) == 0) e = 12'(int'($urandom_range(0, 400)) - 200);
            else e = 12'($urandom);
            f = 10'($urandom);
            run_update(e, f, lat, bcnt, ucnt);
            model_update(e, f);
            vectors++;
            if (lft !== 11'(m_lft) || rht !== 11'(m_rht) || lat !== 4 || ucnt !== 1) begin
                miscompares++;
                $display("FAIL rand%0d got %h/%h lat=%0d n=%0d want %h/%h lat=4 n=1",
                         i, lft, rht, lat, ucnt, 11'(m_lft), 11'(m_rht));
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_sat_hi();
        test_integ_clamp();
        test_back_to_back();
        test_go_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
